uart_program_loader: RTL
========================

Name: uart_program_loader

Overview:
- Boot-time writer for the core's instruction memory. The core only ever reads that memory.
- Consumes a framed byte stream from the UART receiver and assembles little-endian 32-bit words. Writes them to sequential instruction-memory addresses starting at the reset PC.
- Holds the core in reset while loading and returns a one-byte ACK/NAK to the UART transmitter.
- Sits between uart_mmio's RX/TX byte ports and the instruction-memory write port, beside the core.

Parameters:
- BASE_ADDR, 32'h80000000, address of the first word written; equals the core's reset PC.
- MAX_WORDS, 4096, largest accepted word count.
- TIMEOUT_CYCLES, 1_000_000, idle clocks allowed between bytes inside a frame; 0 disables the timeout.
- MAGIC, 8'hA5, frame start byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- ack_valid  out  1  response byte pending for the UART transmitter.
- ack_data  out  8  response byte: 8'h06 ACK, 8'h15 NAK.
- ack_ready  in  1  transmitter accepts ack_data this cycle.
- im_wr_en  out  1  instruction-memory write strobe, one cycle per word.
- im_wr_addr  out  32  word byte address.
- im_wr_data  out  32  assembled word.
- core_hold  out  1  1 = keep the core in reset.
- load_done  out  1  last frame loaded and acknowledged.
- load_error  out  1  last frame rejected or timed out.

Behaviour:
- Reset values (asynchronous on rst_n low):
  - State IDLE, core_hold=1.
  - im_wr_en=0, im_wr_addr=BASE_ADDR, im_wr_data=0.
  - ack_valid=0, ack_data=0, load_done=0, load_error=0.
  - Counters and checksum cleared.
- Frame format: MAGIC, 4-byte word count N (little-endian), 4·N data bytes (each word little-endian), 1 checksum byte. The checksum is the XOR of all data bytes only.
- States: IDLE, LEN, DATA, CSUM, RESP, DONE.
- IDLE:
  - rx_valid with MAGIC → LEN. Clear byte counter, word index and checksum. Set core_hold=1, load_done=0, load_error=0.
  - Any other byte is ignored.
- LEN:
  - Shift 4 bytes into N, LSB first.
  - After the 4th byte: N==0 or N>MAX_WORDS → RESP with NAK and load_error=1. Otherwise → DATA.
- DATA:
  - Place byte k (0..3) into bits [8k+7:8k]; XOR each byte into the checksum.
  - The cycle after the 4th byte is accepted: im_wr_en=1 for exactly one cycle, with im_wr_addr = BASE_ADDR + 4·index and im_wr_data = the assembled word. Then index increments.
  - Address arithmetic is 32-bit and wraps modulo 2^32.
  - When the N-th word's 4th byte is accepted → CSUM.
- CSUM:
  - Byte == checksum → RESP with ACK.
  - Mismatch → RESP with NAK and load_error=1.
- RESP:
  - ack_valid=1 and ack_data stay stable until the cycle ack_ready=1.
  - The cycle after the handshake: ack_valid=0. ACK → DONE with load_done=1. NAK → IDLE.
  - rx_valid is ignored in RESP.
- DONE:
  - core_hold=0.
  - rx_valid with MAGIC → LEN and re-asserts core_hold the next cycle; other bytes are ignored.
- core_hold after a NAK or timeout: stays 1 until a successful frame completes.
- Timeout: in LEN, DATA or CSUM, TIMEOUT_CYCLES consecutive clocks without rx_valid → IDLE with load_error=1 and no response byte.
- Words already written before a NAK or timeout remain in memory; there is no rollback.
- Simultaneous events:
  - rx_valid on the same cycle the timeout expires: the byte wins and the timeout counter reloads.
  - An im_wr_en pulse never coincides with a state change that would drop it; the last word's write issues in the first cycle of CSUM.
- Reset mid-frame: immediate return to IDLE with all reset values.
- No back-pressure on rx: every rx_valid byte is consumed in one cycle. Bytes may arrive on consecutive clocks.

Test Plan:
- Good load: A5 02 00 00 00 13 00 00 00 93 00 10 00 90.
  - im_wr_en pulses twice: (80000000, 00000013) and (80000004, 00100093).
  - ack_data=06; after ack_ready, load_done=1 and core_hold=0.
- Bad checksum: same frame ending 91 → ack_data=15, load_error=1, core_hold=1, both words still written.
- Length rejection: N=0, then N=MAX_WORDS+1 → NAK right after the 4th length byte, no im_wr_en.
- Timeout: TIMEOUT_CYCLES=100; stop after 2 data bytes → 100 clocks later state IDLE, load_error=1, ack_valid never asserted.
- Back-pressure and noise:
  - Hold ack_ready=0 for 50 cycles → ack_valid and ack_data stable throughout.
  - Bytes 00 FF before A5 are ignored.
  - Bytes injected during RESP are dropped.
- Reset and reload:
  - Assert rst_n=0 mid-DATA → all outputs return to reset values.
  - A second good frame sent from DONE → core_hold rises, new words are written, ACK.

Source files
------------

// File: rtl/uart_program_loader.sv
// uart_program_loader
//   Boot-time writer for the core's instruction memory. Receives a framed
//   byte stream from the UART receiver and assembles little-endian 32-bit
//   words. It writes them to sequential addresses starting at BASE_ADDR. It
//   keeps the core in reset while loading and returns a one-byte ACK/NAK.
//
//   Frame: MAGIC, N[7:0], N[15:8], N[23:16], N[31:24], 4*N data bytes
//   (each word LSB first), checksum (XOR of the data bytes only).
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   rx_valid, rx_data   one-cycle strobe with a received byte (never stalled)
//   ack_valid, ack_data response byte (06 ACK / 15 NAK) held until ack_ready
//   ack_ready           transmitter takes ack_data this cycle
//   im_wr_en            one-cycle write strobe per assembled word
//   im_wr_addr          byte address of the word
//   im_wr_data          assembled word
//   core_hold           1 = keep the core in reset
//   load_done           last frame loaded and acknowledged
//   load_error          last frame rejected or timed out
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for MAGIC, core held
// LEN   | shifting in the 4-byte word count
// DATA  | assembling words, one memory write per 4 bytes
// CSUM  | waiting for the checksum byte
// RESP  | ACK/NAK presented to the transmitter until accepted
// DONE  | image loaded, core released; MAGIC starts a reload
module uart_program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h8000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter logic [7:0]  MAGIC          = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        ack_valid,
  output logic [7:0]  ack_data,
  input  logic        ack_ready,
  output logic        im_wr_en,
  output logic [31:0] im_wr_addr,
  output logic [31:0] im_wr_data,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error
);

  localparam logic [7:0]  ACK_BYTE = 8'h06;
  localparam logic [7:0]  NAK_BYTE = 8'h15;
  localparam logic [31:0] MAX_W    = 32'(MAX_WORDS);
  localparam logic [31:0] TMO_LOAD = 32'(TIMEOUT_CYCLES);
  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RESP, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] tmo_q, tmo_d;

  logic        wr_en_d;
  logic [31:0] wr_addr_d, wr_data_d;
  logic        ack_valid_d;
  logic [7:0]  ack_data_d;
  logic        hold_d, done_d, error_d;

  logic [31:0] len_shift, word_shift;
  logic        len_bad, in_frame, tmo_expire, start_frame, last_word;

  // Bytes arrive LSB first, so shifting in from the top leaves the value
  // correctly aligned after the fourth byte.
  assign len_shift   = {rx_data, len_q[31:8]};
  assign word_shift  = {rx_data, word_q[31:8]};
  assign len_bad     = (len_shift == 32'd0) || (len_shift > MAX_W);
  assign in_frame    = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  // A byte on the expiry cycle wins: expiry requires rx_valid low.
  assign tmo_expire  = TMO_EN && in_frame && !rx_valid && (tmo_q == 32'd1);
  assign start_frame = rx_valid && (rx_data == MAGIC) &&
                       ((state_q == IDLE) || (state_q == DONE));
  assign last_word   = ((word_idx_q + 32'd1) == len_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      byte_cnt_q <= 2'd0;
      len_q      <= 32'd0;
      word_q     <= 32'd0;
      word_idx_q <= 32'd0;
      csum_q     <= 8'd0;
      tmo_q      <= 32'd0;
      im_wr_en   <= 1'b0;
      im_wr_addr <= BASE_ADDR;
      im_wr_data <= 32'd0;
      ack_valid  <= 1'b0;
      ack_data   <= 8'd0;
      core_hold  <= 1'b1;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_q     <= word_d;
      word_idx_q <= word_idx_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      im_wr_en   <= wr_en_d;
      im_wr_addr <= wr_addr_d;
      im_wr_data <= wr_data_d;
      ack_valid  <= ack_valid_d;
      ack_data   <= ack_data_d;
      core_hold  <= hold_d;
      load_done  <= done_d;
      load_error <= error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    len_d       = len_q;
    word_d      = word_q;
    word_idx_d  = word_idx_q;
    csum_d      = csum_q;
    tmo_d       = tmo_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = im_wr_addr;
    wr_data_d   = im_wr_data;
    ack_valid_d = ack_valid;
    ack_data_d  = ack_data;
    hold_d      = core_hold;
    done_d      = load_done;
    error_d     = load_error;

    // Inter-byte idle timer: reloads on every byte inside a frame.
    if (in_frame) begin
      if (rx_valid) begin
        tmo_d = TMO_LOAD;
      end else if (tmo_q != 32'd0) begin
        tmo_d = tmo_q - 32'd1;
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
      end

      LEN: begin
        if (rx_valid) begin
          len_d      = len_shift;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (len_bad) begin
              state_d     = RESP;
              ack_valid_d = 1'b1;
              ack_data_d  = NAK_BYTE;
              error_d     = 1'b1;
            end else begin
              state_d = DATA;
            end
          end
        end else if (tmo_expire) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end

      DATA: begin
        if (rx_valid) begin
          word_d     = word_shift;
          csum_d     = csum_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Registered strobe: the write appears the cycle after the
            // 4th byte, which for the last word is the first CSUM cycle.
            wr_en_d    = 1'b1;
            wr_addr_d  = BASE_ADDR + {word_idx_q[29:0], 2'b00};
            wr_data_d  = word_shift;
            word_idx_d = word_idx_q + 32'd1;
            if (last_word) begin
              state_d = CSUM;
            end
          end
        end else if (tmo_expire) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end

      CSUM: begin
        if (rx_valid) begin
          state_d     = RESP;
          ack_valid_d = 1'b1;
          if (rx_data == csum_q) begin
            ack_data_d = ACK_BYTE;
          end else begin
            ack_data_d = NAK_BYTE;
            error_d    = 1'b1;
          end
        end else if (tmo_expire) begin
          state_d = IDLE;
          error_d = 1'b1;
        end
      end

      RESP: begin
        if (ack_ready) begin
          ack_valid_d = 1'b0;
          if (ack_data == ACK_BYTE) begin
            state_d = DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase

    if (start_frame) begin
      state_d    = LEN;
      byte_cnt_d = 2'd0;
      len_d      = 32'd0;
      word_d     = 32'd0;
      word_idx_d = 32'd0;
      csum_d     = 8'd0;
      tmo_d      = TMO_LOAD;
      hold_d     = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
    end
  end

endmodule
